seg7_bank: RTL and testbench



---
 rtl/seg7_pkg.sv | 16 +
 rtl/hex7_decode.sv | 11 +
 rtl/seg7_bank.sv | 112 +++++++++++
 tb/tb_seg7_bank.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display bank: address window, blank
// pattern, raw-mode flag position, digit reset value and the hex glyph table.
package seg7_pkg;

  localparam logic [3:0] SEG7_BASE      = 4'h2;
  localparam logic [6:0] SEG7_BLANK     = 7'h7F;
  localparam int         SEG7_RAW_BIT   = 7;
  localparam logic [7:0] SEG7_DIGIT_RST = 8'h80;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7_decode.sv
// Combinational 4-bit to 7-segment active-low glyph decoder.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_GLYPH[nibble];

endmodule

// File: rtl/seg7_bank.sv
// Memory-mapped eight-digit seven-segment controller in the 0x2000-0x2FFF window.
// Define SEG7_BLINK_EN to build the blink prescaler and control register.
module seg7_bank
  import seg7_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 25
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] DOUT,
  input  logic [15:0] ADDR,
  input  logic        W,
  output logic [15:0] Q,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  logic       cs;
  logic       wr;
  logic [7:0] digit   [8];
  logic [6:0] glyph   [8];
  logic [6:0] pattern [8];
  logic [6:0] hex     [8];
  logic [7:0] blink_mask;
  logic       phase;
  logic       unused_bits;

  assign cs          = (ADDR[15:12] == SEG7_BASE);
  assign wr          = cs & W;
  assign unused_bits = ^{ADDR[11:4], DOUT[15:8]};

  // NOTE: the digit file is only eight bytes, so every entry gets a reset value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) digit[i] <= SEG7_DIGIT_RST;
    end else if (wr && !ADDR[3]) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      digit[ADDR[2:0]] <= DOUT[7:0];
    end
  end

`ifdef SEG7_BLINK_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic             ctrl_wr;
  logic [CNT_W-1:0] cnt;

  assign ctrl_wr = wr & ADDR[3] & (ADDR[2:0] == 3'd0);

  // A control write restarts the blink cycle and takes priority over a wrap.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      blink_mask <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else if (ctrl_wr) begin
      blink_mask <= DOUT[7:0];
      cnt        <= '0;
      phase      <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      phase      <= ~phase;
    end else begin
      cnt        <= cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_cfg = BLINK_DIV + CNT_W;

  assign blink_mask = '0;
  assign phase      = 1'b0;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_digit
    hex7_decode u_dec (
      .nibble (digit[i][3:0]),
      .seg    (glyph[i])
    );
    assign pattern[i] = digit[i][SEG7_RAW_BIT] ? digit[i][6:0] : glyph[i];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) hex[i] <= SEG7_BLANK;
    end else begin
      for (int i = 0; i < 8; i++)
        hex[i] <= (blink_mask[i] & phase) ? SEG7_BLANK : pattern[i];
    end
  end

  always_comb begin
    Q = 16'h0000;
    if (cs) Q = ADDR[3] ? {8'h00, blink_mask} : {8'h00, digit[ADDR[2:0]]};
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
  assign HEX6 = hex[6];
  assign HEX7 = hex[7];

endmodule

// File: tb/tb_seg7_bank.sv
// Self-checking bench for seg7_bank: directed vector table plus blink and reset
// sequences (blink checks apply when SEG7_BLINK_EN is defined).
module tb_seg7_bank;

  logic        Clock;
  logic        Reset;
  logic [15:0] DOUT;
  logic [15:0] ADDR;
  logic        W;
  logic [15:0] Q;
  logic [6:0]  hex [8];

  int n_vec = 0;
  int n_err = 0;

  seg7_bank #(.BLINK_DIV(4), .CNT_W(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .DOUT  (DOUT),
    .ADDR  (ADDR),
    .W     (W),
    .Q     (Q),
    .HEX0  (hex[0]),
    .HEX1  (hex[1]),
    .HEX2  (hex[2]),
    .HEX3  (hex[3]),
    .HEX4  (hex[4]),
    .HEX5  (hex[5]),
    .HEX6  (hex[6]),
    .HEX7  (hex[7])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          idx;
    logic [6:0]  hex_exp;
    logic [15:0] q_exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    ADDR = addr;
    DOUT = data;
    W    = 1'b1;
    tick();
    W    = 1'b0;
  endtask

  task automatic check_q(input string name, input logic [15:0] addr, input logic [15:0] exp);
    ADDR = addr;
    #1;
    check(name, Q, exp);
  endtask

  // Expected HEX0 for a digit holding 'A' with blink_mask[0] set, m edges after the control write.
  function automatic logic [6:0] blink_exp(input int m);
    return (((m - 1) / 4) % 2 == 1) ? 7'h7F : 7'h08;
  endfunction

  initial begin
    vecs[0]  = '{16'h2003, 16'h0005, 3, 7'h12, 16'h0005};
    vecs[1]  = '{16'h2007, 16'hFF80, 7, 7'h00, 16'h0080};
    vecs[2]  = '{16'h2000, 16'h000A, 0, 7'h08, 16'h000A};
    vecs[3]  = '{16'h2011, 16'h000C, 1, 7'h46, 16'h000C};
    vecs[4]  = '{16'h2FF5, 16'hAB0E, 5, 7'h06, 16'h000E};
    vecs[5]  = '{16'h2006, 16'h00F6, 6, 7'h76, 16'h00F6};
    vecs[6]  = '{16'h1003, 16'h0009, 3, 7'h12, 16'h0000};
    vecs[7]  = '{16'h3003, 16'h0009, 3, 7'h12, 16'h0000};
    vecs[8]  = '{16'h200C, 16'h00FF, 0, 7'h08, 16'h0000};
    vecs[9]  = '{16'h2004, 16'h0002, 4, 7'h24, 16'h0002};
    vecs[10] = '{16'h2002, 16'h000B, 2, 7'h03, 16'h000B};
    vecs[11] = '{16'h2001, 16'h0008, 1, 7'h00, 16'h0008};

    Reset = 1'b1;
    DOUT  = 16'h0000;
    ADDR  = 16'h0000;
    W     = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) check($sformatf("reset_hex%0d", i), {9'd0, hex[i]}, 16'h007F);
    check_q("reset_q_digit0", 16'h2000, 16'h0080);
    check_q("reset_q_ctrl",   16'h2008, 16'h0000);
    check_q("reset_q_nocs",   16'h1000, 16'h0000);
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 12; v++) begin
      do_write(vecs[v].addr, vecs[v].data);
      check_q($sformatf("vec%0d_q", v), vecs[v].addr, vecs[v].q_exp);
      tick();
      check($sformatf("vec%0d_hex%0d", v, vecs[v].idx), {9'd0, hex[vecs[v].idx]}, {9'd0, vecs[v].hex_exp});
    end
    check_q("digit3_kept", 16'h2003, 16'h0005);

    // Back-to-back writes on consecutive cycles.
    do_write(16'h2005, 16'h0001);
    do_write(16'h2006, 16'h0007);
    check_q("b2b_q5", 16'h2005, 16'h0001);
    check_q("b2b_q6", 16'h2006, 16'h0007);
    check("b2b_hex5", {9'd0, hex[5]}, 16'h0079);
    tick();
    check("b2b_hex6", {9'd0, hex[6]}, 16'h0078);

`ifdef SEG7_BLINK_EN
    do_write(16'h2008, 16'h0001);
    check_q("ctrl_q", 16'h2008, 16'h0001);
    for (int m = 1; m <= 3; m++) begin
      tick();
      check($sformatf("pre_wrap_m%0d", m), {9'd0, hex[0]}, {9'd0, blink_exp(m)});
    end
    // This control write lands on the prescaler wrap edge; the clear must win.
    do_write(16'h2008, 16'h0001);
    for (int m = 1; m <= 12; m++) begin
      tick();
      check($sformatf("blink_m%0d", m), {9'd0, hex[0]}, {9'd0, blink_exp(m)});
    end
    tick();
    check("blink_m13", {9'd0, hex[0]}, 16'h007F);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midblink_reset_hex0", {9'd0, hex[0]}, 16'h007F);
    check_q("midblink_reset_mask", 16'h2008, 16'h0000);
    do_write(16'h2000, 16'h000A);
    for (int m = 1; m <= 10; m++) begin
      tick();
      check($sformatf("post_reset_m%0d", m), {9'd0, hex[0]}, 16'h0008);
    end
`else
    do_write(16'h2008, 16'h0001);
    check_q("ctrl_q_disabled", 16'h2008, 16'h0000);
    for (int m = 1; m <= 10; m++) begin
      tick();
      check($sformatf("noblink_m%0d", m), {9'd0, hex[0]}, 16'h0008);
    end
`endif

    // Reset coinciding with a write: the write is discarded.
    Reset = 1'b1;
    ADDR  = 16'h2002;
    DOUT  = 16'h0001;
    W     = 1'b1;
    tick();
    Reset = 1'b0;
    W     = 1'b0;
    check("rst_wr_hex2", {9'd0, hex[2]}, 16'h007F);
    check_q("rst_wr_q2", 16'h2002, 16'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
